dst_reg_pipe: RTL

Parametrised successor to the 2:1 destination-register mux. It selects the write-back destination register from rt, rd, or a fixed link register, and tracks that destination through DEPTH in-flight pipeline stages. It flags read-after-write hazards and forwarding distance for the decode-stage source addresses. It sits between decode and the register file in the pipelined processor. The last stage drives the register-file write port.

---
 rtl/dst_reg_pipe_if.sv | 41 ++++
 rtl/dst_reg_pipe.sv | 101 ++++++++++
 2 files changed

// File: rtl/dst_reg_pipe_if.sv
// Decode-side bundle for dst_reg_pipe: destination select inputs, pipeline
// control, decode source addresses, and the write-back / hazard outputs.
interface dst_reg_pipe_if #(
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 3
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [1:0]        RegDst;
  logic              RegWrite;
  logic              valid_in;
  logic              stall;
  logic              flush;
  logic [ADDR_W-1:0] mux_in_a;
  logic [ADDR_W-1:0] mux_in_b;
  logic [ADDR_W-1:0] rs_addr;
  logic [ADDR_W-1:0] rt_addr;
  logic [ADDR_W-1:0] mux_out;
  logic              wb_we;
  logic [ADDR_W-1:0] wb_addr;
  logic              hazard_rs;
  logic              hazard_rt;
  logic [CNT_W-1:0]  fwd_rs;
  logic [CNT_W-1:0]  fwd_rt;
  logic [CNT_W-1:0]  pending_count;

  // Decode stage drives the request side.
  modport master (
    output RegDst, RegWrite, valid_in, stall, flush,
    output mux_in_a, mux_in_b, rs_addr, rt_addr,
    input  mux_out, wb_we, wb_addr, hazard_rs, hazard_rt,
    input  fwd_rs, fwd_rt, pending_count
  );

  modport slave (
    input  RegDst, RegWrite, valid_in, stall, flush,
    input  mux_in_a, mux_in_b, rs_addr, rt_addr,
    output mux_out, wb_we, wb_addr, hazard_rs, hazard_rt,
    output fwd_rs, fwd_rt, pending_count
  );
endinterface

// File: rtl/dst_reg_pipe.sv
// Destination-register select plus a DEPTH-stage in-flight write tracker that
// drives the register-file write port and reports RAW hazards / forward distance.
module dst_reg_pipe #(
  parameter int ADDR_W   = 5,
  parameter int DEPTH    = 3,
  parameter int LINK_REG = 31
) (
  input  logic          clk,
  input  logic          reset,
  dst_reg_pipe_if.slave bus
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    DST_RT   = 2'b00,
    DST_RD   = 2'b01,
    DST_LINK = 2'b10,
    DST_NONE = 2'b11
  } reg_dst_e;

  typedef struct packed {
    logic              v;
    logic [ADDR_W-1:0] addr;
  } entry_t;

  entry_t            stage_q [DEPTH];
  entry_t            stage_d [DEPTH];
  entry_t            new_entry;
  logic [ADDR_W-1:0] dst_sel;

  // Destination select; codes 00/01 keep the legacy 2:1 mux behaviour.
  always_comb begin
    dst_sel = '0;
    unique case (reg_dst_e'(bus.RegDst))
      DST_RT:   dst_sel = bus.mux_in_b;
      DST_RD:   dst_sel = bus.mux_in_a;
      DST_LINK: dst_sel = ADDR_W'(LINK_REG);
      DST_NONE: dst_sel = '0;
      default:  dst_sel = '0;
    endcase
  end

  assign bus.mux_out = dst_sel;

  // Register 0 is never a real destination, so it is folded into "invalid".
  always_comb begin
    new_entry.v    = bus.valid_in & bus.RegWrite & (dst_sel != '0);
    new_entry.addr = new_entry.v ? dst_sel : '0;
  end

  // Stall injects a bubble but keeps the rest draining; flush additionally
  // kills the instruction currently in stage 0 so it never shifts to stage 1.
  always_comb begin
    // NOTE: every element gets a default before the conditional updates, so
    // no path through this block can leave stage_d holding an inferred latch.
    stage_d = '{default: '0};
    stage_d[0] = (bus.flush || bus.stall) ? '0 : new_entry;
    for (int k = 1; k < DEPTH; k++) begin
      stage_d[k] = (bus.flush && (k == 1)) ? '0 : stage_q[k-1];
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every stage
    // samples its neighbour's pre-edge value; blocking here would collapse
    // the shift into a single-cycle pass-through.
    if (reset) begin
      stage_q <= '{default: '0};
    end else begin
      stage_q <= stage_d;
    end
  end

  assign bus.wb_we   = stage_q[DEPTH-1].v;
  assign bus.wb_addr = stage_q[DEPTH-1].addr;

  // Walk oldest to youngest so the youngest match is the one left standing.
  always_comb begin
    bus.hazard_rs = 1'b0;
    bus.hazard_rt = 1'b0;
    bus.fwd_rs    = '0;
    bus.fwd_rt    = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (stage_q[k].v && (stage_q[k].addr == bus.rs_addr) && (bus.rs_addr != '0)) begin
        bus.hazard_rs = 1'b1;
        bus.fwd_rs    = CNT_W'(k + 1);
      end
      if (stage_q[k].v && (stage_q[k].addr == bus.rt_addr) && (bus.rt_addr != '0)) begin
        bus.hazard_rt = 1'b1;
        bus.fwd_rt    = CNT_W'(k + 1);
      end
    end
  end

  always_comb begin
    bus.pending_count = '0;
    for (int k = 0; k < DEPTH; k++) begin
      bus.pending_count = bus.pending_count + CNT_W'(stage_q[k].v);
    end
  end
endmodule
